// File: rtl/nmos_pkg.sv
// ============================================================================
// Module      : nmos_pkg
// Description : Shared types and the stack-node rule for the NMOS AND3 cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nmos_pkg;

  localparam int NMOS_MAX_N = 8;

  typedef struct packed {
    logic val;
    logic drv;
  } node_t;

  // x is padded with ones above the real stack depth.
  // "Everything above k is on" then also covers the top node of a shorter stack.
  function automatic node_t stack_node(input int k, input logic [NMOS_MAX_N-1:0] x);
    node_t n;
    logic  lo;
    logic  hi;
    lo = 1'b1;
    hi = 1'b1;
    for (int i = 0; i < NMOS_MAX_N; i++) begin
      if (i <= k) lo = lo & x[i];
      else        hi = hi & x[i];
    end
    if (lo) begin
      n.val = 1'b0;
      n.drv = 1'b1;
    end else if (hi) begin
      n.val = 1'b1;
      n.drv = 1'b1;
    end else begin
      n.val = 1'b0;
      n.drv = 1'b0;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nmos_stack.sv
// ============================================================================
// Module      : nmos_stack
// Description : Combinational series pull-down stack; one node_t per node.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nmos_stack
  import nmos_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] x,
  output node_t        nodes [N]
);

  logic [NMOS_MAX_N-1:0] x_pad;

  always_comb begin
    x_pad        = '1;
    x_pad[N-1:0] = x;
  end

  for (genvar k = 0; k < N; k++) begin : g_node
    assign nodes[k] = stack_node(k, x_pad);
  end

endmodule

`default_nettype wire

// File: rtl/nmos_and3_cell.sv
// ============================================================================
// Module      : nmos_and3_cell
// Description : Registered NMOS AND gate (pull-down stack + inverter).
//               Define NMOS_NODE_DEBUG_EN to expose per-node w_val / w_drv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nmos_and3_cell
  import nmos_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
`ifdef NMOS_NODE_DEBUG_EN
  output logic [N-1:0] w_val,
  output logic [N-1:0] w_drv,
`endif
  output logic         y
);

  logic [N-1:0] x_q;
  node_t        top_node;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) x_q <= '0;
    else     x_q <= x;
  end

`ifdef NMOS_NODE_DEBUG_EN
  node_t nodes [N];

  nmos_stack #(.N(N)) u_stack (
    .x     (x_q),
    .nodes (nodes)
  );

  for (genvar k = 0; k < N; k++) begin : g_dbg
    assign w_val[k] = nodes[k].val;
    assign w_drv[k] = nodes[k].drv;
  end

  assign top_node = nodes[N-1];
`else
  logic [NMOS_MAX_N-1:0] x_pad;

  always_comb begin
    x_pad        = '1;
    x_pad[N-1:0] = x_q;
  end

  assign top_node = stack_node(N - 1, x_pad);
`endif

  // Top node is always driven, so gating with drv leaves y = ~val.
  assign y = top_node.drv & ~top_node.val;

endmodule

`default_nettype wire

// File: tb/tb_nmos_and3_cell.sv
// Directed bench for nmos_and3_cell: vector table plus reset sequences.
`default_nettype none
`timescale 1ns/1ps

module tb_nmos_and3_cell;

  logic       clk;
  logic       rst;
  logic [2:0] x;
  logic       y;
`ifdef NMOS_NODE_DEBUG_EN
  logic [2:0] w_val;
  logic [2:0] w_drv;
`endif

  int passed;
  int total;

  nmos_and3_cell #(.N(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
`ifdef NMOS_NODE_DEBUG_EN
    .w_val (w_val),
    .w_drv (w_drv),
`endif
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] x;
    logic       y;
    logic [2:0] val;
    logic [2:0] drv;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk_nodes(input string name, input logic [2:0] val, input logic [2:0] drv);
`ifdef NMOS_NODE_DEBUG_EN
    chk({name, ".w_val"}, {5'd0, w_val}, {5'd0, val});
    chk({name, ".w_drv"}, {5'd0, w_drv}, {5'd0, drv});
`else
    if (val === 3'bx && drv === 3'bx) $display("unreachable");
`endif
  endtask

  initial begin
    passed = 0;
    total  = 0;

    vecs[0] = '{3'b000, 1'b0, 3'b100, 3'b100};
    vecs[1] = '{3'b001, 1'b0, 3'b100, 3'b101};
    vecs[2] = '{3'b010, 1'b0, 3'b100, 3'b100};
    vecs[3] = '{3'b011, 1'b0, 3'b100, 3'b111};
    vecs[4] = '{3'b100, 1'b0, 3'b110, 3'b110};
    vecs[5] = '{3'b101, 1'b0, 3'b110, 3'b111};
    vecs[6] = '{3'b110, 1'b0, 3'b111, 3'b111};
    vecs[7] = '{3'b111, 1'b1, 3'b000, 3'b111};

    // Reset held across edges with all inputs high
    rst = 1'b1;
    x   = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.y", {7'd0, y}, 8'd0);
    chk_nodes("reset", 3'b100, 3'b100);

    // Release between edges; first capture is on the next edge
    @(negedge clk);
    rst = 1'b0;
    x   = 3'b000;

    // Sweep: apply, clock once, compare
    for (int i = 0; i < 8; i++) begin
      x = vecs[i].x;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.y", i), {7'd0, y}, {7'd0, vecs[i].y});
      chk_nodes($sformatf("vec%0d", i), vecs[i].val, vecs[i].drv);
    end

    // Back-to-back: each cycle's output reflects the previous cycle's input
    x = 3'b111;
    @(posedge clk);
    #1;
    x = 3'b110;
    chk("b2b.y1", {7'd0, y}, 8'd1);
    @(posedge clk);
    #1;
    chk("b2b.y0", {7'd0, y}, 8'd0);

    // Mid-run asynchronous reset
    x = 3'b111;
    @(posedge clk);
    #1;
    chk("midrst.pre", {7'd0, y}, 8'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.async", {7'd0, y}, 8'd0);
    chk_nodes("midrst", 3'b100, 3'b100);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst.held", {7'd0, y}, 8'd0);
    @(posedge clk);
    #1;
    chk("midrst.post", {7'd0, y}, 8'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nmos_and3_cell.md
# nmos_and3_cell

Clocked, synthesizable behavioural model of an NMOS-logic 3-input AND gate. The gate is built from a series NMOS pull-down stack with a resistive (rnmos) pull-up, followed by an NMOS inverter stage with a resistive pull-up. The block registers its inputs and computes the output and all internal stack-node states from the registered inputs. It sits in the switch-level logic library as the reference cell that gate-level AND3 instances are checked against.

## Interface
- `N`, default 3: stack depth, i.e. the number of AND inputs; legal range 2..8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `x` input N: gate inputs; `x[0]` drives the transistor nearest ground.
- `y` output 1: AND of the registered inputs.
- `w_val` output N: logic value of each stack node; present only with `NMOS_NODE_DEBUG_EN`.
- `w_drv` output N: 1 when the corresponding node is driven, 0 when it is floating; present only with `NMOS_NODE_DEBUG_EN`.

## Operation
- Input register `x_q` is loaded from `x` on every rising edge of `clk`.
- Stack model, with node `w[k]` sitting above transistor `k` (gate `x_q[k]`):
  - Node `w[k]` is pulled to 0 when `x_q[0..k]` are all 1, because a strong path to ground exists.
  - Otherwise, if `k == N-1`, or `x_q[k+1..N-1]` are all 1, the node is connected to the rnmos pull-up and reads 1.
  - Otherwise the node is floating: `w_drv[k]` = 0 and `w_val[k]` = 0 (floating nodes report 0).
  - The strong pull-down always beats the weak pull-up; there is no contention state.
- Top node `w[N-1]` is always driven.
- Inverter stage: `y = ~w_val[N-1]`. This makes `y` equal to the AND-reduction of `x_q`.
- All outputs are derived combinationally from `x_q`. There is no other state.

## Timing
- Latency from `x` to `y` is 1 cycle: a value applied before edge `n` appears on `y` after edge `n`.
- While `rst` is high, `x_q` is held at 0. This gives `y` = 0, `w_val` = {1'b1, (N-1){1'b0}}, and `w_drv` = {1'b1, (N-1){1'b0}}.
- Reset asserted mid-operation clears `x_q` immediately, without waiting for a clock edge.
- The first post-reset capture happens on the first rising edge after `rst` deasserts.
- No handshake: the block accepts a new input every cycle.

## Configuration
- `NMOS_NODE_DEBUG_EN` defined: the `w_val` and `w_drv` ports exist and are driven as described above.
- `NMOS_NODE_DEBUG_EN` undefined:
  - Those ports are omitted.
  - Node evaluation is reduced to the top node only.
  - `y` behaviour and timing are identical to the debug build.

## Structure
- Shared package `nmos_pkg` holds:
  - `NMOS_MAX_N` = 8.
  - Typedef `node_t`, a struct of `{val, drv}`.
  - Function `stack_node(k, x)` implementing the node rules.
- Sub-module `nmos_stack`: combinational, parameterised by `N`; maps `x_q` to per-node `node_t`. The top level holds the register, the inverter and the port gating.

## Test plan
- Reset: assert `rst` with `x` = 3'b111 → `y` = 0, `w_val` = 3'b100, `w_drv` = 3'b100.
- Exhaustive sweep: `x` = 0..7, one per cycle → `y` one cycle later is 0 for 0..6 and 1 for 7.
- `x` = 3'b011 → `w_val` = 3'b100, `w_drv` = 3'b111, `y` = 0.
- `x` = 3'b010 → `w_drv` = 3'b100, `w_val` = 3'b100 (w0 and w1 floating), `y` = 0.
- `x` = 3'b110 → `w_val` = 3'b111, `w_drv` = 3'b111, `y` = 0.
- Mid-run reset: with `x` = 3'b111 and `y` = 1, pulse `rst` between edges → `y` drops to 0 asynchronously and returns to 1 on the first edge after release.
